// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with pending-write scoreboard and a
// post-reset sequential clear engine (one entry per cycle, x0 excluded).
// Optional build macro: REG_FILE_SB_BYPASS_EN forwards the writeback port to
// the read ports and iss_busy within the same cycle.
module reg_file_sb #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              ready,
  input  logic              wr_enable,
  input  logic [AW-1:0]     rd_address,
  input  logic [XLEN-1:0]   rd_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_busy,
  input  logic [NRD*AW-1:0] rs_address,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [NREGS-1:0]  r_busy;
  logic [XLEN-1:0]   r_mem [NREGS];

  state_t            w_state_nxt;
  logic [AW-1:0]     w_idx_nxt;
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [XLEN-1:0]   w_mem_wdata;
  logic              w_wb_hit;
  logic              w_iss_hit;

  // Qualified writeback / issue strobes; only meaningful in RUN.
  always_comb begin
    w_wb_hit  = (r_state == S_RUN) && wr_enable && (rd_address != '0);
    w_iss_hit = (r_state == S_RUN) && iss_valid && (iss_rd != '0);
  end

  // Next-state: clear sequencing, array write selection and scoreboard update.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_idx;
    w_mem_wdata = '0;
    unique case (r_state)
      S_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_idx;
        w_idx_nxt  = r_idx + 1'b1;
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_wb_hit) begin
          w_mem_we               = 1'b1;
          w_mem_addr             = rd_address;
          w_mem_wdata            = rd_data;
          w_busy_nxt[rd_address] = 1'b0;
        end
        // Set after clear so a same-cycle issue to the written register wins.
        if (w_iss_hit) begin
          w_busy_nxt[iss_rd] = 1'b1;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // State, scoreboard and array; the array shares the reset branch so no write
  // can land on an edge where reset_n is low, but its contents are not reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_idx   <= AW'(1);
      r_busy  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_mem_we) begin
        r_mem[w_mem_addr] <= w_mem_wdata;
      end
    end
  end

  // Combinational read ports and issue-side busy lookup; x0 always reads 0/idle.
  always_comb begin
    ready    = (r_state == S_RUN);
    rs_data  = '0;
    rs_busy  = '0;
    iss_busy = 1'b0;
    if (r_state == S_RUN) begin
      for (int unsigned k = 0; k < NRD; k++) begin
        if (rs_address[k*AW +: AW] != '0) begin
          rs_data[k*XLEN +: XLEN] = r_mem[rs_address[k*AW +: AW]];
          rs_busy[k]              = r_busy[rs_address[k*AW +: AW]];
        end
`ifdef REG_FILE_SB_BYPASS_EN
        if (w_wb_hit && (rd_address == rs_address[k*AW +: AW])) begin
          rs_data[k*XLEN +: XLEN] = rd_data;
          rs_busy[k]              = 1'b0;
        end
`endif
      end
      if (iss_rd != '0) begin
        iss_busy = r_busy[iss_rd];
      end
`ifdef REG_FILE_SB_BYPASS_EN
      if (w_wb_hit && (rd_address == iss_rd)) begin
        iss_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default-size instance checked with a vector table,
// hand sequences and a randomized run against an array model; a small
// instance (XLEN=16, NREGS=8, NRD=3) checked with a hand sequence.
module tb_reg_file_sb;

  // ---------------- default instance ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        wr_enable;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_busy;
  logic [9:0]  rs_address;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;

  // ---------------- small instance ----------------
  logic        s_reset_n;
  logic        s_ready;
  logic        s_wr_enable;
  logic [2:0]  s_rd_address;
  logic [15:0] s_rd_data;
  logic        s_iss_valid;
  logic [2:0]  s_iss_rd;
  logic        s_iss_busy;
  logic [8:0]  s_rs_address;
  logic [47:0] s_rs_data;
  logic [2:0]  s_rs_busy;

  always #5 clock = ~clock;

  reg_file_sb dut (
    .clock(clock), .reset_n(reset_n), .ready(ready),
    .wr_enable(wr_enable), .rd_address(rd_address), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_busy(iss_busy),
    .rs_address(rs_address), .rs_data(rs_data), .rs_busy(rs_busy)
  );

  reg_file_sb #(.XLEN(16), .NREGS(8), .NRD(3)) dut_s (
    .clock(clock), .reset_n(s_reset_n), .ready(s_ready),
    .wr_enable(s_wr_enable), .rd_address(s_rd_address), .rd_data(s_rd_data),
    .iss_valid(s_iss_valid), .iss_rd(s_iss_rd), .iss_busy(s_iss_busy),
    .rs_address(s_rs_address), .rs_data(s_rs_data), .rs_busy(s_rs_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_d(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (default instance) ----------------
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  int          m_edges;

  function automatic bit m_ready();
    return m_edges >= 31;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_edges = 0;
  endtask

  task automatic model_edge();
    if (m_ready()) begin
      if (wr_enable && rd_address != 5'd0) begin
        m_mem[rd_address]  = rd_data;
        m_busy[rd_address] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
    m_edges++;
  endtask

  task automatic check_model(input string tag);
    logic [4:0]  a;
    logic [31:0] ed;
    bit          eb;
    bit          fwd;
    chk_b({tag, ".ready"}, ready, m_ready());
    for (int p = 0; p < 2; p++) begin
      a   = rs_address[p*5 +: 5];
      ed  = '0;
      eb  = 1'b0;
      fwd = 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
      fwd = wr_enable && rd_address != 5'd0 && rd_address == a;
`endif
      if (m_ready() && a != 5'd0) begin
        ed = fwd ? rd_data : m_mem[a];
        eb = fwd ? 1'b0 : m_busy[a];
      end
      chk_d($sformatf("%s.rs_data%0d[x%0d]", tag, p, a), rs_data[p*32 +: 32], ed);
      chk_b($sformatf("%s.rs_busy%0d[x%0d]", tag, p, a), rs_busy[p], eb);
    end
    fwd = 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    fwd = wr_enable && rd_address != 5'd0 && rd_address == iss_rd;
`endif
    chk_b({tag, ".iss_busy"}, iss_busy,
          m_ready() && iss_rd != 5'd0 && !fwd && m_busy[iss_rd]);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_enable  = 1'b0;
    rd_address = '0;
    rd_data    = '0;
    iss_valid  = 1'b0;
    iss_rd     = '0;
    rs_address = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic        ib;
  } vec_t;

  vec_t tbl [12];
  bit   fwd_on;
  int   lowc;

  initial begin
    fwd_on = 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    fwd_on = 1'b1;
`endif
    //            we    wa     wd            iv    ir     r0     r1     d0            d1            b0    b1    ib
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'd7, 32'h00000055, 1'b0, 5'd9, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'd9, 32'h000000AA, 1'b1, 5'd9, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd9, 5'd9, 32'hAA,       32'hAA,       1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd0, 32'h55,       32'h0,        1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd7, 32'h0,        32'h55,       1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};

    idle();
    s_wr_enable = 1'b0; s_rd_address = '0; s_rd_data = '0;
    s_iss_valid = 1'b0; s_iss_rd = '0; s_rs_address = '0;
    reset_n   = 1'b0;
    s_reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_b("reset.ready", ready, 1'b0);
    chk_b("reset.rs_busy0", rs_busy[0], 1'b0);

    // Release reset while hammering x3 with writes and issues during CLEAR.
    wr_enable = 1'b1; rd_address = 5'd3; rd_data = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 5'd3; rs_address = {5'd3, 5'd3};
    reset_n = 1'b1;
    lowc = 0;
    for (int c = 0; c < 100; c++) begin
      if (ready) break;
      #1 check_model("clear");
      lowc++;
      tick();
    end
    chk_d("ready_low_cycles", 32'(lowc), 32'd31);

    idle();
    for (int a = 0; a < 32; a++) begin
      rs_address = {5'(a), 5'(a)};
      #1;
      chk_d($sformatf("sweep.p0[x%0d]", a), rs_data[31:0], 32'h0);
      chk_d($sformatf("sweep.p1[x%0d]", a), rs_data[63:32], 32'h0);
      chk_b($sformatf("sweep.busy[x%0d]", a), rs_busy[0] | rs_busy[1], 1'b0);
    end

    // Vector table: outputs sampled before the edge that commits each row.
    for (int i = 0; i < 12; i++) begin
      wr_enable = tbl[i].we; rd_address = tbl[i].wa; rd_data = tbl[i].wd;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ir;
      rs_address = {tbl[i].r1, tbl[i].r0};
      #1;
      chk_d($sformatf("tbl%0d.d0", i), rs_data[31:0],  tbl[i].d0);
      chk_d($sformatf("tbl%0d.d1", i), rs_data[63:32], tbl[i].d1);
      chk_b($sformatf("tbl%0d.b0", i), rs_busy[0], tbl[i].b0);
      chk_b($sformatf("tbl%0d.b1", i), rs_busy[1], tbl[i].b1);
      chk_b($sformatf("tbl%0d.ib", i), iss_busy,   tbl[i].ib);
      check_model($sformatf("tbl%0d", i));
      tick();
    end

    // Writeback to busy x7 (data 0x55): forwarding only with bypass.
    idle();
    wr_enable = 1'b1; rd_address = 5'd7; rd_data = 32'h66;
    iss_rd = 5'd7; rs_address = {5'd7, 5'd7};
    #1;
    chk_d("wbcyc.d0", rs_data[31:0], fwd_on ? 32'h66 : 32'h55);
    chk_b("wbcyc.b0", rs_busy[0], !fwd_on);
    chk_b("wbcyc.ib", iss_busy, !fwd_on);
    tick();
    wr_enable = 1'b0;
    #1;
    chk_d("wbnext.d1", rs_data[63:32], 32'h66);
    chk_b("wbnext.b1", rs_busy[1], 1'b0);
    chk_b("wbnext.ib", iss_busy, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_enable  = 1'($urandom_range(0, 1));
      rd_address = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      rd_data    = $urandom;
      iss_valid  = 1'($urandom_range(0, 1));
      iss_rd     = ($urandom_range(0, 2) == 0) ? rd_address : 5'($urandom_range(0, 5));
      rs_address[4:0] = ($urandom_range(0, 3) == 0) ? rd_address : 5'($urandom_range(0, 7));
      rs_address[9:5] = ($urandom_range(0, 3) == 0) ? rs_address[4:0] : 5'($urandom_range(0, 31));
      #1 check_model("rand");
      tick();
    end

    // Mid-RUN asynchronous reset with x3 (0x77) and x4 busy.
    idle();
    wr_enable = 1'b1; rd_address = 5'd3; rd_data = 32'h77;
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    wr_enable = 1'b0; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd3; rs_address = {5'd4, 5'd3};
    #1;
    chk_d("prerst.x3", rs_data[31:0], 32'h77);
    chk_b("prerst.b3", rs_busy[0], 1'b1);
    chk_b("prerst.b4", rs_busy[1], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_b("midrst.ready", ready, 1'b0);
    chk_b("midrst.b3", rs_busy[0], 1'b0);
    chk_b("midrst.b4", rs_busy[1], 1'b0);
    chk_b("midrst.ib", iss_busy, 1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    lowc = 0;
    for (int c = 0; c < 100; c++) begin
      if (ready) break;
      lowc++;
      tick();
    end
    chk_d("rerst.ready_low_cycles", 32'(lowc), 32'd31);
    #1;
    chk_d("rerst.x3", rs_data[31:0], 32'h0);
    chk_b("rerst.b3", rs_busy[0], 1'b0);
    chk_b("rerst.b4", rs_busy[1], 1'b0);

    // Small instance: 8 entries, three read ports, 16-bit data.
    @(posedge clock);
    #1 s_reset_n = 1'b1;
    lowc = 0;
    for (int c = 0; c < 50; c++) begin
      if (s_ready) break;
      lowc++;
      @(posedge clock);
      #1;
    end
    chk_d("small.ready_low_cycles", 32'(lowc), 32'd7);
    s_wr_enable = 1'b1; s_rd_address = 3'd1; s_rd_data = 16'h1234;
    @(posedge clock); #1;
    s_rd_address = 3'd6; s_rd_data = 16'hBEEF; s_iss_valid = 1'b1; s_iss_rd = 3'd6;
    @(posedge clock); #1;
    s_wr_enable = 1'b0; s_iss_valid = 1'b0;
    s_rs_address = {3'd6, 3'd1, 3'd1};
    #1;
    chk_b("small.ready", s_ready, 1'b1);
    chk_d("small.p0", 32'(s_rs_data[15:0]),  32'h1234);
    chk_d("small.p1", 32'(s_rs_data[31:16]), 32'h1234);
    chk_d("small.p2", 32'(s_rs_data[47:32]), 32'hBEEF);
    chk_d("small.busy", 32'(s_rs_busy), 32'b100);
    chk_b("small.ib6", s_iss_busy, 1'b1);
    s_iss_valid = 1'b1; s_iss_rd = 3'd1;
    @(posedge clock); #1;
    s_iss_valid = 1'b0;
    #1;
    chk_d("small.busy2", 32'(s_rs_busy), 32'b111);
    chk_d("small.p2b", 32'(s_rs_data[47:32]), 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with a pending-write scoreboard and a sequential clear engine, the successor of the fixed 32x32, two-read-port register file. It sits between decode/issue and writeback:
- Issue marks destination registers busy.
- Writeback stores results and clears busy bits.
- Read ports return data plus a per-port busy flag so issue logic can stall.
- After reset the array is zeroed one entry per cycle; `ready` flags completion.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, register count, power of two, ≥ 4; `AW = $clog2(NREGS)` is derived, not overridable.
- `NRD`, 2, number of read ports, 1..4.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `ready`  out  1  high once the array is cleared and the block accepts traffic.
- `wr_enable`  in  1  writeback strobe.
- `rd_address`  in  AW  writeback destination.
- `rd_data`  in  XLEN  writeback data.
- `iss_valid`  in  1  issue strobe for an instruction that writes `iss_rd`.
- `iss_rd`  in  AW  destination to mark busy.
- `iss_busy`  out  1  current scoreboard bit of `iss_rd` (0 for x0), combinational.
- `rs_address`  in  NRD*AW  packed read addresses; port k is at `[k*AW +: AW]`.
- `rs_data`  out  NRD*XLEN  packed read data, combinational.
- `rs_busy`  out  NRD  per-port scoreboard flag, combinational.

## Operation
- State machine: CLEAR, RUN.
- Reset (`reset_n` low, asynchronous) forces:
  - state CLEAR, clear index = 1, `ready` = 0;
  - all busy bits = 0.
  - Array contents are not reset asynchronously.
- CLEAR:
  - Each cycle writes 0 to `register[idx]` and increments idx.
  - On the cycle idx == NREGS-1 it writes that entry and moves to RUN.
  - `wr_enable` and `iss_valid` are ignored.
  - `rs_data` = 0, `rs_busy` = 0, `iss_busy` = 0.
- RUN:
  - `ready` = 1.
  - Writeback: `wr_enable` with `rd_address` != 0 writes `rd_data` and clears `busy[rd_address]` at the clock edge.
  - Issue: `iss_valid` with `iss_rd` != 0 sets `busy[iss_rd]` at the clock edge.
  - Issue to an already-busy register is accepted and the bit stays set. Avoiding WAW hazards is upstream's job via `iss_busy`.
  - Simultaneous writeback and issue to the same register: the set wins, so the bit is 1 after the edge and the data is still written.
- Register x0:
  - reads return 0;
  - writes are dropped;
  - never busy;
  - issue to x0 has no effect.
- Read port k: `rs_data[k]` = `register[rs_address[k]]`; `rs_busy[k]` = `busy[rs_address[k]]`.
  - Same-cycle interaction with writeback is set by BYPASS_EN (see Configuration).
- Several read ports may address the same register; each returns identical results.

## Timing
- Read latency: 0 cycles (combinational from `rs_address` and state).
- Write-to-read latency: 1 cycle without bypass, 0 with bypass.
- Issue to busy visible: 1 cycle. Writeback to busy cleared: 1 cycle, or 0 on read ports with bypass.
- Ready latency: `ready` rises on the edge ending cycle NREGS-1 after the first rising edge with `reset_n` high (31 cycles at default).
- Reset mid-CLEAR or mid-RUN:
  - aborts the current operation immediately;
  - clearing restarts from index 1;
  - busy bits are lost;
  - no partial write may occur on the edge coincident with `reset_n` low.

## Configuration
- `REG_FILE_SB_BYPASS_EN` defined:
  - When `wr_enable` is high, `rd_address` != 0 and `rd_address` == `rs_address[k]` in RUN, then `rs_data[k]` = `rd_data` and `rs_busy[k]` = 0 in the same cycle.
  - The same forwarding applies to `iss_busy`.
- Not defined:
  - Reads return the stored value and the old busy bit until the edge after writeback.
  - No combinational path exists from `rd_data` or `wr_enable` to any output.

## Test plan
- Reset release, defaults → `ready` low for exactly 31 cycles, then high. All `rs_data` = 0 for every address. Writes issued during CLEAR are not stored.
- RUN: write x5 = 0xDEADBEEF, then read x5 on ports 0 and 1 next cycle → both return 0xDEADBEEF and `rs_busy` = 0. Write to x0 with 0x1234 → x0 reads 0.
- Issue x7, then read x7 → `rs_busy` = 1 from the next cycle. Writeback x7 = 0x55 → busy clears and data = 0x55 after the edge.
  - With BYPASS_EN: 0x55 and busy = 0 appear in the writeback cycle itself.
- Same-cycle issue x9 and writeback x9 = 0xAA → after the edge x9 reads 0xAA and `busy[9]` = 1.
- Assert `reset_n` low mid-RUN with x3, x4 busy and x3 = 0x77 → `ready` drops asynchronously and busy bits read 0. After release, x3 reads 0 once `ready` returns.
- `NREGS` = 8, `NRD` = 3, `XLEN` = 16: `ready` after 7 cycles. Three ports read x1, x1 and x6 concurrently → values correct and `rs_busy` independent per port.
